// File: rtl/fb_plot_sink.sv
// fb_plot_sink: receiving end of the pixel-plot interface.
//   Captures vga_x/vga_y/vga_colour plot strobes into a 160x120x3 frame store.
//   It can clear the store to CLEAR_COLOUR, and it can read the store back in raster order
//   over a valid/ready stream.
//
// Ports
//   clk, rst       single rising-edge clock, asynchronous active-high reset
//   vga_x/y/colour plot coordinate and colour, written when vga_plot is high
//   vga_plot       plot strobe, one write per cycle
//   clear_start    request a clear pass (honoured only when idle or done)
//   scan_start     request a raster readout (honoured only when idle or done)
//   busy           clearing or scanning
//   scan_done      readout finished, held until the next start
//   pix_x/y/colour presented pixel, stable until accepted
//   pix_valid      pixel presented
//   pix_ready      downstream accepts the presented pixel
//   dropped_count  saturating count of rejected plots
module fb_plot_sink #(
   parameter int unsigned H_RES        = 160,
   parameter int unsigned V_RES        = 120,
   parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  vga_x,
   input  logic [6:0]  vga_y,
   input  logic [2:0]  vga_colour,
   input  logic        vga_plot,
   input  logic        clear_start,
   input  logic        scan_start,
   output logic        busy,
   output logic        scan_done,
   output logic [7:0]  pix_x,
   output logic [6:0]  pix_y,
   output logic [2:0]  pix_colour,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] dropped_count
);

   localparam int unsigned Depth    = H_RES * V_RES;
   localparam logic [7:0]  XLast    = 8'(H_RES - 1);
   localparam logic [6:0]  YLast    = 7'(V_RES - 1);
   localparam logic [14:0] AddrLast = 15'(Depth - 1);

   typedef enum logic [2:0] {StIdle, StClear, StScanRd, StScanOut, StDone} state_e;

   state_e      state_q, state_d;
   logic [14:0] cnt_q, cnt_d;
   logic [7:0]  x_q, x_d;
   logic [6:0]  y_q, y_d;
   logic [2:0]  colour_q;
   logic [15:0] drop_q;

   logic [2:0]  mem [Depth];

   logic        in_range, plot_ok, plot_drop;
   logic        wr_en;
   logic [14:0] wr_addr, scan_addr;
   logic [2:0]  wr_data;

   // y*160 + x as shifts; the row stride is fixed at 160.
   function automatic logic [14:0] addr_of(input logic [7:0] x, input logic [6:0] y);
      return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   endfunction

   // ---------------------------------------------------------------- plot path
   always_comb begin
      in_range  = (vga_x <= XLast) && (vga_y <= YLast);
      plot_ok   = vga_plot && in_range && (state_q != StClear);
      plot_drop = vga_plot && !plot_ok;
   end

   // The clear pass owns the write port; plots are rejected while it runs.
   always_comb begin
      wr_en     = 1'b0;
      wr_addr   = addr_of(vga_x, vga_y);
      wr_data   = vga_colour;
      scan_addr = addr_of(x_q, y_q);
      if (state_q == StClear) begin
         wr_en   = 1'b1;
         wr_addr = cnt_q;
         wr_data = CLEAR_COLOUR;
      end else if (plot_ok) begin
         wr_en = 1'b1;
      end
   end

   // Frame store is not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Synchronous read port; a same-edge write to this address is seen next time (old data here).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         colour_q <= 3'b000;
      end else if (state_q == StScanRd) begin
         colour_q <= mem[scan_addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_q <= 16'h0000;
      end else if (plot_drop && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 15'd0;
         x_q     <= 8'd0;
         y_q     <= 7'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         StIdle, StDone: begin
            if (clear_start) begin
               state_d = StClear;
               cnt_d   = 15'd0;
            end else if (scan_start) begin
               state_d = StScanRd;
               cnt_d   = 15'd0;
               x_d     = 8'd0;
               y_d     = 7'd0;
            end
         end
         StClear: begin
            if (cnt_q == AddrLast) begin
               state_d = StIdle;
               cnt_d   = 15'd0;
            end else begin
               cnt_d = cnt_q + 15'd1;
            end
         end
         StScanRd: begin
            state_d = StScanOut;
         end
         StScanOut: begin
            if (pix_ready) begin
               if ((x_q == XLast) && (y_q == YLast)) begin
                  state_d = StDone;
               end else begin
                  state_d = StScanRd;
                  if (x_q == XLast) begin
                     x_d = 8'd0;
                     y_d = y_q + 7'd1;
                  end else begin
                     x_d = x_q + 8'd1;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q == StClear) || (state_q == StScanRd) || (state_q == StScanOut);
      scan_done = (state_q == StDone);
      pix_valid = (state_q == StScanOut);
   end

   assign pix_x         = x_q;
   assign pix_y         = y_q;
   assign pix_colour    = colour_q;
   assign dropped_count = drop_q;

endmodule

// File: tb/tb_fb_plot_sink.sv
module tb_fb_plot_sink;

   localparam int Npix = 19200;

   logic        clk;
   logic        rst;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        clear_start;
   logic        scan_start;
   logic        busy;
   logic        scan_done;
   logic [7:0]  pix_x;
   logic [6:0]  pix_y;
   logic [2:0]  pix_colour;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] dropped_count;

   fb_plot_sink dut (
      .clk           (clk),
      .rst           (rst),
      .vga_x         (vga_x),
      .vga_y         (vga_y),
      .vga_colour    (vga_colour),
      .vga_plot      (vga_plot),
      .clear_start   (clear_start),
      .scan_start    (scan_start),
      .busy          (busy),
      .scan_done     (scan_done),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .pix_colour    (pix_colour),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .dropped_count (dropped_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t       exp_q[$];
   logic [2:0] model [Npix];
   int         n_cmp;
   int         n_err;
   int         emitted;
   int         exp_drop;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pix_t expect_at(input int idx);
      pix_t p;
      p.x = 8'(idx % 160);
      p.y = 7'(idx / 160);
      p.c = model[idx];
      return p;
   endfunction

   // One plot strobe; inputs change on the falling edge.
   task automatic plot(input int x, input int y, input logic [2:0] c);
      vga_x      = 8'(x);
      vga_y      = 7'(y);
      vga_colour = c;
      vga_plot   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vga_plot = 1'b0;
      if (x < 160 && y < 120) model[y*160 + x] = c;
      else exp_drop++;
   endtask

   // Raster readout. Returns early (at a falling edge) when pixel stop_idx is presented.
   task automatic run_scan(input int stop_idx, input bit rnd, input bit mid_plot);
      pix_t       e;
      bit         held;
      bit         mid_done;
      bit         r;
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
      held     = 1'b0;
      mid_done = 1'b0;
      emitted  = 0;
      exp_q.delete();
      exp_q.push_back(expect_at(0));
      scan_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      scan_start = 1'b0;
      for (int cyc = 0; cyc < 60000; cyc++) begin
         if (held) begin
            check("held_valid", pix_valid, 1);
            check("held_x", pix_x, px);
            check("held_y", pix_y, py);
            check("held_colour", pix_colour, pc);
         end
         held = 1'b0;
         if (pix_valid) begin
            if (stop_idx >= 0 && emitted == stop_idx) return;
            if (mid_plot && !mid_done && pix_x == 8'd10 && pix_y == 7'd0) begin
               pix_ready = 1'b0;
               px = pix_x; py = pix_y; pc = pix_colour;
               plot(20, 0, 3'b010);
               check("midplot_hold_x", pix_x, px);
               plot(5, 0, 3'b010);
               mid_done = 1'b1;
               held     = 1'b1;
               continue;
            end
            r = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            pix_ready = r;
            if (r) begin
               if (exp_q.size() == 0) begin
                  check("extra_pixel", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("pix_x", pix_x, e.x);
                  check("pix_y", pix_y, e.y);
                  check("pix_colour", pix_colour, e.c);
               end
               emitted++;
               if (emitted < Npix) exp_q.push_back(expect_at(emitted));
            end else begin
               held = 1'b1;
               px = pix_x; py = pix_y; pc = pix_colour;
            end
         end else begin
            pix_ready = 1'($urandom_range(0, 1));
         end
         if (scan_done) break;
         @(posedge clk);
         @(negedge clk);
      end
      pix_ready = 1'b0;
      if (stop_idx >= 0) check("stop_pixel_reached", 0, 1);
   endtask

   int busy_cycles;

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      exp_drop    = 0;
      rst         = 1'b1;
      vga_x       = '0;
      vga_y       = '0;
      vga_colour  = '0;
      vga_plot    = 1'b0;
      clear_start = 1'b0;
      scan_start  = 1'b0;
      pix_ready   = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_scan_done", scan_done, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_dropped", dropped_count, 0);
      check("rst_pix_x", pix_x, 0);
      check("rst_pix_y", pix_y, 0);
      check("rst_pix_colour", pix_colour, 0);
      rst = 1'b0;
      @(negedge clk);

      // Clear pass: busy for exactly 19200 cycles; one plot rejected mid-clear.
      clear_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_start = 1'b0;
      busy_cycles = 0;
      while (busy && busy_cycles < 20000) begin
         busy_cycles++;
         if (busy_cycles == 100) begin
            check("clear_no_valid", pix_valid, 0);
            vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'b111; vga_plot = 1'b1;
            exp_drop++;
         end else begin
            vga_plot = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      vga_plot = 1'b0;
      check("clear_busy_cycles", busy_cycles, Npix);
      for (int i = 0; i < Npix; i++) model[i] = 3'b000;

      // Valid plots, then out-of-range plots.
      plot(0, 0, 3'b101);
      plot(159, 119, 3'b011);
      plot(80, 60, 3'b111);
      plot(160, 5, 3'b110);
      plot(5, 120, 3'b110);
      plot(255, 127, 3'b110);
      check("dropped_after_plots", dropped_count, exp_drop);
      check("dropped_is_4", dropped_count, 4);

      // Full scan, random backpressure, plots ahead of and behind the scan position.
      run_scan(-1, 1'b1, 1'b1);
      check("full_scan_count", emitted, Npix);
      check("full_scan_done", scan_done, 1);
      check("full_scan_busy", busy, 0);
      check("full_scan_queue_empty", exp_q.size(), 0);
      check("full_scan_model_20", model[20], 3'b010);
      check("dropped_after_scan", dropped_count, 4);

      // Reset mid-scan at (100,50).
      run_scan(50*160 + 100, 1'b0, 1'b0);
      check("stop_x", pix_x, 100);
      check("stop_y", pix_y, 50);
      check("stop_valid", pix_valid, 1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", pix_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_dropped", dropped_count, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Restart from (0,0).
      run_scan(4, 1'b0, 1'b0);
      check("restart_emitted", emitted, 4);

      // Both starts together from IDLE: clear wins.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clear_start = 1'b1;
      scan_start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_start = 1'b0;
      scan_start  = 1'b0;
      check("both_start_busy", busy, 1);
      check("both_start_valid", pix_valid, 0);
      repeat (5) @(negedge clk);
      check("both_start_still_busy", busy, 1);
      check("both_start_no_valid", pix_valid, 0);
      check("both_start_not_done", scan_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
